// File: rtl/puf_pkg.sv
// ============================================================================
// Module      : puf_pkg
// Description : Shared types and constants for the RO-PUF sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package puf_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_RUN     = 3'd2,
      ST_SETTLE  = 3'd3,
      ST_COMPARE = 3'd4,
      ST_DONE    = 3'd5
   } puf_seq_state_t;

   localparam int DEF_WINDOW_CYCLES = 1024;
   localparam int DEF_SETTLE_CYCLES = 4;
   localparam int MAJ_VOTES         = 3;

   // Index width with a floor of one bit so a single-bit response still has an index.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

`default_nettype wire

// File: rtl/puf_window_timer.sv
// ============================================================================
// Module      : puf_window_timer
// Description : Loadable down-counter; tc marks the last cycle of the loaded span.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module puf_window_timer #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             tc
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/puf_sequencer.sv
// ============================================================================
// Module      : puf_sequencer
// Description : Runs one clear/count/settle/compare measurement per challenge
//               bit and assembles the ring-oscillator PUF response.
//               Optional macro PUF_MAJORITY_EN: three votes per bit, majority wins.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module puf_sequencer
   import puf_pkg::*;
#(
   parameter int RESP_BITS     = 8,
   parameter int CNT_W         = 16,
   parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req,
   input  logic [RESP_BITS-1:0] challenge,
   output logic                 busy,
   output logic                 done,
   output logic [RESP_BITS-1:0] response,
   output logic                 ro_sel,
   output logic                 cnt_clr,
   output logic                 cnt_en,
   input  logic [CNT_W-1:0]     cnt_a,
   input  logic [CNT_W-1:0]     cnt_b
);

   localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int IDX_W = idx_width(RESP_BITS);

   puf_seq_state_t       state, next_state;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [RESP_BITS-1:0] challenge_q, chal_nxt;
   logic                 win_tc, set_tc;
   logic                 cmp, last_bit, bit_done, bit_val, ro_sel_nxt;

   puf_window_timer #(.WIDTH(WIN_W)) u_win_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == ST_CLEAR),
      .load_val (WIN_W'(WINDOW_CYCLES)),
      .tc       (win_tc)
   );

   puf_window_timer #(.WIDTH(SET_W)) u_set_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     ((state == ST_RUN) && win_tc),
      .load_val (SET_W'(SETTLE_CYCLES)),
      .tc       (set_tc)
   );

   assign cmp      = (cnt_a > cnt_b);
   assign last_bit = (idx == IDX_W'(RESP_BITS - 1));

`ifdef PUF_MAJORITY_EN
   logic [1:0] vote_cnt;
   logic [1:0] ones;

   assign bit_done = (vote_cnt == 2'(MAJ_VOTES - 1));
   assign bit_val  = (2'(ones + {1'b0, cmp}) >= 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vote_cnt <= '0;
         ones     <= '0;
      end else if (state == ST_IDLE || (state == ST_COMPARE && bit_done)) begin
         vote_cnt <= '0;
         ones     <= '0;
      end else if (state == ST_COMPARE) begin
         vote_cnt <= vote_cnt + 2'd1;
         ones     <= 2'(ones + {1'b0, cmp});
      end
   end
`else
   assign bit_done = 1'b1;
   assign bit_val  = cmp;
`endif

   always_comb begin
      next_state = state;
      idx_nxt    = idx;
      chal_nxt   = challenge_q;
      case (state)
         ST_IDLE: begin
            if (req) begin
               next_state = ST_CLEAR;
               idx_nxt    = '0;
               chal_nxt   = challenge;
            end
         end
         ST_CLEAR:  next_state = ST_RUN;
         ST_RUN:    if (win_tc) next_state = ST_SETTLE;
         ST_SETTLE: if (set_tc) next_state = ST_COMPARE;
         ST_COMPARE: begin
            if (bit_done && last_bit) begin
               next_state = ST_DONE;
            end else begin
               next_state = ST_CLEAR;
               if (bit_done) idx_nxt = IDX_W'(idx + 1'b1);
            end
         end
         ST_DONE:   next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
      ro_sel_nxt = 1'b0;
      if (next_state inside {ST_CLEAR, ST_RUN, ST_SETTLE, ST_COMPARE})
         ro_sel_nxt = chal_nxt[idx_nxt];
   end

   // Outputs are registered from the next-state decode so they align with the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         idx         <= '0;
         challenge_q <= '0;
         response    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ro_sel      <= 1'b0;
         cnt_clr     <= 1'b0;
         cnt_en      <= 1'b0;
      end else begin
         state       <= next_state;
         idx         <= idx_nxt;
         challenge_q <= chal_nxt;
         busy        <= (next_state != ST_IDLE);
         done        <= (next_state == ST_DONE);
         ro_sel      <= ro_sel_nxt;
         cnt_clr     <= (next_state == ST_CLEAR);
         cnt_en      <= (next_state == ST_RUN);
         if (state == ST_IDLE && req)
            response <= '0;
         else if (state == ST_COMPARE && bit_done)
            response[idx] <= bit_val;
      end
   end

endmodule

`default_nettype wire
